axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/axi4_lite_master.sv | 168 ++++++++++++++++
 tb/tb_axi4_lite_master.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master: FSM state encoding and response codes.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one write or read per start pulse.
// Optional abort watchdog compiled in with AXI4L_MASTER_TIMEOUT_EN.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_req_complete;
  logic              tmo_hit;

  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign WDATA  = wdata_q;

  // A channel whose VALID is already low in WR_REQ has finished its handshake.
  assign wr_req_complete = (!AWVALID || AWREADY) && (!WVALID || WREADY);

`ifdef AXI4L_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      resp    <= OKAY;
      addr_q  <= '0;
      wdata_q <= '0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      // busy stays up through the done cycle so a start there is ignored
      if (done) begin
        busy <= 1'b0;
      end

      if (tmo_hit) begin
        AWVALID <= 1'b0;
        WVALID  <= 1'b0;
        BREADY  <= 1'b0;
        ARVALID <= 1'b0;
        RREADY  <= 1'b0;
        resp    <= SLVERR;
        done    <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !busy) begin
              addr_q  <= addr;
              wdata_q <= wdata;
              busy    <= 1'b1;
              if (write) begin
                AWVALID <= 1'b1;
                WVALID  <= 1'b1;
                state   <= WR_REQ;
              end else begin
                ARVALID <= 1'b1;
                state   <= RD_REQ;
              end
            end
          end

          WR_REQ: begin
            if (AWVALID && AWREADY) begin
              AWVALID <= 1'b0;
            end
            if (WVALID && WREADY) begin
              WVALID <= 1'b0;
            end
            if (wr_req_complete) begin
              BREADY <= 1'b1;
              state  <= WR_RESP;
            end
          end

          WR_RESP: begin
            if (BVALID && BREADY) begin
              BREADY <= 1'b0;
              resp   <= BRESP;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end

          RD_REQ: begin
            if (ARVALID && ARREADY) begin
              ARVALID <= 1'b0;
              RREADY  <= 1'b1;
              state   <= RD_RESP;
            end
          end

          RD_RESP: begin
            if (RVALID && RREADY) begin
              RREADY <= 1'b0;
              rdata  <= RDATA;
              resp   <= RRESP;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a reactive AXI4-Lite slave model.
// Timeout scenario is built only when AXI4L_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_master;

  logic        ACLK;
  logic        ARESETn;
  logic        start;
  logic        write;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;

  int n_chk  = 0;
  int n_fail = 0;

  axi4_lite_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .resp(resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave configuration, written only by the stimulus process
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          r_delay  = 0;
  logic        b_en     = 1'b1;
  logic [1:0]  b_resp   = 2'b00;
  logic [1:0]  r_resp   = 2'b00;
  logic [31:0] r_data   = 32'h0;

  // Slave state
  int   aw_wait, w_wait, r_cnt;
  logic aw_got, w_got, r_pend;
  logic aw_hs, w_hs;

  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign AWREADY = AWVALID && (aw_wait >= aw_delay);
  assign WREADY  = WVALID && (w_wait >= w_delay);
  assign ARREADY = ARVALID;
  assign BRESP   = b_resp;
  assign RRESP   = r_resp;
  assign RDATA   = r_data;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_wait <= 0; w_wait <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      BVALID <= 1'b0; RVALID <= 1'b0;
    end else begin
      aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        BVALID <= b_en;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        if (r_delay == 0) RVALID <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= 1; end
      end else if (r_pend) begin
        if (r_cnt == r_delay) begin RVALID <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Event counters and VALID-stability monitor
  int   done_cnt = 0, aw_cnt = 0, ar_cnt = 0, viol = 0;
  logic aw_wait_prev = 1'b0, w_wait_prev = 1'b0;
  logic [3:0]  awaddr_prev;
  logic [31:0] wdata_prev;

  always @(negedge ACLK) begin
    if (done) done_cnt++;
    if (ARESETn) begin
      if (aw_wait_prev && (!AWVALID || AWADDR !== awaddr_prev)) viol++;
      if (w_wait_prev && (!WVALID || WDATA !== wdata_prev)) viol++;
      aw_wait_prev = AWVALID && !AWREADY;
      w_wait_prev  = WVALID && !WREADY;
    end else begin
      aw_wait_prev = 1'b0;
      w_wait_prev  = 1'b0;
    end
    awaddr_prev = AWADDR;
    wdata_prev  = WDATA;
  end

  always @(posedge ACLK) begin
    if (aw_hs) aw_cnt++;
    if (ARVALID && ARREADY) ar_cnt++;
  end

  // Presents start for one cycle; returns 1 ns after the accepting edge (cycle 1).
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d);
    @(negedge ACLK);
    start = 1'b1; write = wr; addr = a; wdata = d;
    @(posedge ACLK);
    #1;
    start = 1'b0;
  endtask

  // Cycle index of the done pulse counted from the start cycle (0); -1 if none.
  task automatic wait_done(input int from_cyc, output int lat);
    int c;
    c = from_cyc;
    while (!done && c < 300) begin
      @(posedge ACLK);
      #1;
      c++;
    end
    lat = done ? c : -1;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if ({busy, done, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {busy, done, AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
    n_chk++; if (rdata !== 32'h0 || resp !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: rdata=%h resp=%b expected 0/00", rdata, resp); end
    n_chk++; if (AWADDR !== 4'h0 || WDATA !== 32'h0 || ARADDR !== 4'h0) begin
      n_fail++; $display("FAIL reset_regs: awaddr=%h wdata=%h araddr=%h expected 0",
        AWADDR, WDATA, ARADDR); end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    n_chk++; if (busy !== 1'b0 || AWVALID !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy=%b awvalid=%b expected 0/0", busy, AWVALID); end
  endtask

  task automatic test_write_basic;
    int lat, d0;
    aw_delay = 0; w_delay = 0; b_resp = 2'b00;
    d0 = done_cnt;
    issue(1'b1, 4'h4, 32'hDEADBEEF);
    n_chk++; if (AWVALID !== 1'b1 || WVALID !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wr_valids: aw=%b w=%b busy=%b expected 1/1/1", AWVALID, WVALID, busy); end
    n_chk++; if (AWADDR !== 4'h4 || WDATA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_payload: awaddr=%h wdata=%h expected 4/deadbeef", AWADDR, WDATA); end
    wait_done(1, lat);
    n_chk++; if (lat !== 3) begin
      n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_chk++; if (resp !== 2'b00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wr_resp: resp=%b busy=%b expected 00/1", resp, busy); end
    @(posedge ACLK); #1;
    n_chk++; if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL wr_done_pulse: done=%b busy=%b pulses=%0d expected 0/0/1",
        done, busy, done_cnt - d0); end
  endtask

  task automatic test_write_delayed;
    int lat, d0, v0;
    aw_delay = 1; w_delay = 5; b_resp = 2'b10;
    d0 = done_cnt; v0 = viol;
    issue(1'b1, 4'h8, 32'hCAFEF00D);
    repeat (2) begin @(posedge ACLK); #1; end
    n_chk++; if (AWVALID !== 1'b0 || WVALID !== 1'b1) begin
      n_fail++; $display("FAIL wr_split_hs: aw=%b w=%b expected 0/1", AWVALID, WVALID); end
    wait_done(3, lat);
    n_chk++; if (lat !== 8) begin
      n_fail++; $display("FAIL wr_delay_latency: got %0d expected 8", lat); end
    n_chk++; if (resp !== 2'b10) begin
      n_fail++; $display("FAIL wr_bresp_capture: got %b expected 10", resp); end
    @(posedge ACLK); #1;
    n_chk++; if (done_cnt - d0 !== 1 || viol - v0 !== 0) begin
      n_fail++; $display("FAIL wr_delay_stable: pulses=%0d violations=%0d expected 1/0",
        done_cnt - d0, viol - v0); end
    aw_delay = 0; w_delay = 0; b_resp = 2'b00;
  endtask

  task automatic test_read;
    int lat, d0;
    r_delay = 3; r_data = 32'h12345678; r_resp = 2'b00;
    d0 = done_cnt;
    issue(1'b0, 4'hC, 32'h0);
    n_chk++; if (ARVALID !== 1'b1 || ARADDR !== 4'hC || AWVALID !== 1'b0) begin
      n_fail++; $display("FAIL rd_request: arvalid=%b araddr=%h awvalid=%b expected 1/c/0",
        ARVALID, ARADDR, AWVALID); end
    wait_done(1, lat);
    n_chk++; if (lat !== 6) begin
      n_fail++; $display("FAIL rd_delay_latency: got %0d expected 6", lat); end
    n_chk++; if (rdata !== 32'h12345678 || resp !== 2'b00) begin
      n_fail++; $display("FAIL rd_capture: rdata=%h resp=%b expected 12345678/00", rdata, resp); end
    @(posedge ACLK); #1;
    n_chk++; if (done_cnt - d0 !== 1 || RREADY !== 1'b0) begin
      n_fail++; $display("FAIL rd_done_once: pulses=%0d rready=%b expected 1/0",
        done_cnt - d0, RREADY); end
    r_delay = 0; r_data = 32'hA5A55A5A; r_resp = 2'b10;
    issue(1'b0, 4'h3, 32'h0);
    wait_done(1, lat);
    n_chk++; if (lat !== 3 || rdata !== 32'hA5A55A5A || resp !== 2'b10) begin
      n_fail++; $display("FAIL rd_fast: lat=%0d rdata=%h resp=%b expected 3/a5a55a5a/10",
        lat, rdata, resp); end
    @(posedge ACLK); #1;
    r_resp = 2'b00;
  endtask

  task automatic test_start_while_busy;
    int lat, d0, aw0, ar0;
    w_delay = 3;
    d0 = done_cnt; aw0 = aw_cnt; ar0 = ar_cnt;
    issue(1'b1, 4'h2, 32'h0BADF00D);
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      start = 1'b1; write = 1'b0; addr = 4'h9;
      @(posedge ACLK); #1;
      start = 1'b0;
    end
    n_chk++; if (AWADDR !== 4'h2 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL busy_addr_hold: awaddr=%h arvalid=%b expected 2/0", AWADDR, ARVALID); end
    wait_done(3, lat);
    n_chk++; if (lat !== 6) begin
      n_fail++; $display("FAIL busy_latency: got %0d expected 6", lat); end
    repeat (2) begin @(posedge ACLK); #1; end
    n_chk++; if (aw_cnt - aw0 !== 1 || ar_cnt - ar0 !== 0 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL busy_ignored: aw=%0d ar=%0d done=%0d expected 1/0/1",
        aw_cnt - aw0, ar_cnt - ar0, done_cnt - d0); end
    w_delay = 0;
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b1, 4'h6, 32'h11112222);
    wait_done(1, lat);
    @(posedge ACLK); #1;
    n_chk++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_low: got %b expected 0", busy); end
    r_data = 32'h33334444;
    issue(1'b0, 4'h6, 32'h0);
    n_chk++; if (ARVALID !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: arvalid=%b busy=%b expected 1/1", ARVALID, busy); end
    wait_done(1, lat);
    n_chk++; if (lat !== 3 || rdata !== 32'h33334444) begin
      n_fail++; $display("FAIL b2b_read: lat=%0d rdata=%h expected 3/33334444", lat, rdata); end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid;
    int d0;
    w_delay = 100;
    d0 = done_cnt;
    issue(1'b1, 4'hA, 32'h55AA55AA);
    repeat (3) begin @(posedge ACLK); #1; end
    n_chk++; if (WVALID !== 1'b1) begin
      n_fail++; $display("FAIL mid_wvalid_wait: got %b expected 1", WVALID); end
    #2;
    ARESETn = 1'b0;
    #1;
    n_chk++; if ({AWVALID, WVALID, ARVALID, BREADY, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b expected 000000",
        {AWVALID, WVALID, ARVALID, BREADY, busy, done}); end
    n_chk++; if (AWADDR !== 4'h0 || WDATA !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_regs: awaddr=%h wdata=%h expected 0/0", AWADDR, WDATA); end
    w_delay = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) begin @(posedge ACLK); #1; end
    n_chk++; if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_no_done: pulses=%0d busy=%b expected 0/0",
        done_cnt - d0, busy); end
  endtask

`ifdef AXI4L_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int lat;
    b_en = 1'b0;
    issue(1'b1, 4'h1, 32'h77778888);
    wait_done(1, lat);
    n_chk++; if (lat !== 17) begin
      n_fail++; $display("FAIL tmo_latency: got %0d expected 17", lat); end
    n_chk++; if (resp !== 2'b10 || BREADY !== 1'b0 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
      n_fail++; $display("FAIL tmo_abort: resp=%b bready=%b aw=%b w=%b expected 10/0/0/0",
        resp, BREADY, AWVALID, WVALID); end
    @(posedge ACLK); #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: busy=%b done=%b expected 0/0", busy, done); end
    b_en = 1'b1;
  endtask
`endif

  initial begin
    ARESETn = 1'b0;
    start = 1'b0; write = 1'b0; addr = 4'h0; wdata = 32'h0;
    test_reset();
    test_write_basic();
    test_write_delayed();
    test_read();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef AXI4L_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
